// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: forwarding-mux
// select encoding, the packed control word and counter helpers.
package hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Forwarding mux select; 2'b11 is never produced.
   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

   // 12-bit pipeline control word driving forwarding muxes and pipe registers.
   typedef struct packed {
      fwd_sel_t rs1mux_sel;
      fwd_sel_t rs2mux_sel;
      logic     pipe_load_ifid;
      logic     pipe_load_idex;
      logic     pipe_load_exmem;
      logic     pipe_load_memwb;
      logic     pipe_rst_ifid;
      logic     pipe_rst_idex;
      logic     pipe_rst_exmem;
      logic     pipe_rst_memwb;
   } control_t;

   // Saturating increment: a counter parked at all-ones stays there.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one EX source operand. The EX/MEM result is the
// youngest and wins over MEM/WB; x0 is never forwarded.
module fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] src_i,
   input  logic [REG_W-1:0] mem_rd_i,
   input  logic             mem_we_i,
   input  logic [REG_W-1:0] wb_rd_i,
   input  logic             wb_we_i,
   output fwd_sel_t         sel_o
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_we_i & (mem_rd_i != '0) & (mem_rd_i == src_i);
   assign wb_hit  = wb_we_i  & (wb_rd_i  != '0) & (wb_rd_i  == src_i);

   // Priority pick: EX/MEM, then MEM/WB, else register file.
   always_comb begin
      sel_o = FWD_RF;
      if (mem_hit) begin
         sel_o = FWD_EXMEM;
      end else if (wb_hit) begin
         sel_o = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline. Produces the
// control word (forwarding selects, pipe register load/clear), the PC
// enable, the cache response holding-register controls and the stall and
// flush performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [REG_W-1:0] ex_rs1,
   input  logic [REG_W-1:0] ex_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_load_regfile,
   input  logic             ex_dcache_read,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_load_regfile,
   input  logic             mem_dcache_read,
   input  logic             mem_dcache_write,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_load_regfile,
   input  logic             icache_read,
   input  logic             icache_resp,
   input  logic             dcache_resp,
   input  logic             br_taken,
   output control_t         ctrl,
   output logic             pc_load,
   output logic             ibuf_load,
   output logic             ibuf_sel,
   output logic             icache_mask,
   output logic             dbuf_load,
   output logic             dbuf_sel,
   output logic             dcache_mask,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // Held flags: a response was captured while the other cache froze us.
   logic i_held_q, i_held_d;
   logic d_held_q, d_held_d;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic i_wait;
   logic d_wait;
   logic freeze;
   logic lu_src;
   logic id_hit_rs1;
   logic id_hit_rs2;
   logic lu;
   logic stall_evt;
   logic flush_evt;

   fwd_sel_t rs1_sel;
   fwd_sel_t rs2_sel;

   // A side is waiting when it requests, has nothing held and no pulse now.
   assign i_wait = icache_read & ~i_held_q & ~icache_resp;
   assign d_wait = (mem_dcache_read | mem_dcache_write) & ~d_held_q & ~dcache_resp;
   assign freeze = i_wait | d_wait;

   // Load in EX whose destination feeds a source actually read in ID.
   assign lu_src     = ex_dcache_read & ex_load_regfile & (ex_rd != '0);
   assign id_hit_rs1 = id_uses_rs1 & (id_rs1 == ex_rd);
   assign id_hit_rs2 = id_uses_rs2 & (id_rs2 == ex_rd);
   assign lu         = lu_src & (id_hit_rs1 | id_hit_rs2);

   // A redirect squashes the dependent instruction, so it masks load-use.
   assign stall_evt = freeze | (lu & ~br_taken);
   assign flush_evt = br_taken & ~freeze;

   fwd_unit u_fwd_rs1 (
      .src_i    (ex_rs1),
      .mem_rd_i (mem_rd),
      .mem_we_i (mem_load_regfile),
      .wb_rd_i  (wb_rd),
      .wb_we_i  (wb_load_regfile),
      .sel_o    (rs1_sel)
   );

   fwd_unit u_fwd_rs2 (
      .src_i    (ex_rs2),
      .mem_rd_i (mem_rd),
      .mem_we_i (mem_load_regfile),
      .wb_rd_i  (wb_rd),
      .wb_we_i  (wb_load_regfile),
      .sel_o    (rs2_sel)
   );

   // Control word: freeze beats redirect beats load-use bubble beats run.
   always_comb begin
      ctrl            = '0;
      ctrl.rs1mux_sel = rs1_sel;
      ctrl.rs2mux_sel = rs2_sel;
      pc_load         = 1'b0;
      if (freeze) begin
         pc_load = 1'b0;
      end else if (br_taken) begin
         ctrl.pipe_load_ifid  = 1'b1;
         ctrl.pipe_load_idex  = 1'b1;
         ctrl.pipe_load_exmem = 1'b1;
         ctrl.pipe_load_memwb = 1'b1;
         ctrl.pipe_rst_ifid   = 1'b1;
         ctrl.pipe_rst_idex   = 1'b1;
         pc_load              = 1'b1;
      end else if (lu) begin
         ctrl.pipe_load_idex  = 1'b1;
         ctrl.pipe_load_exmem = 1'b1;
         ctrl.pipe_load_memwb = 1'b1;
         ctrl.pipe_rst_idex   = 1'b1;
      end else begin
         ctrl.pipe_load_ifid  = 1'b1;
         ctrl.pipe_load_idex  = 1'b1;
         ctrl.pipe_load_exmem = 1'b1;
         ctrl.pipe_load_memwb = 1'b1;
         pc_load              = 1'b1;
      end
   end

   // A response can only need holding while the other side keeps us frozen.
   assign ibuf_load   = icache_resp & freeze;
   assign dbuf_load   = dcache_resp & freeze;
   assign ibuf_sel    = i_held_q;
   assign icache_mask = i_held_q;
   assign dbuf_sel    = d_held_q;
   assign dcache_mask = d_held_q;

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

   // Next state: flags survive only while frozen; counters saturate.
   always_comb begin
      i_held_d    = freeze ? (i_held_q | ibuf_load) : 1'b0;
      d_held_d    = freeze ? (d_held_q | dbuf_load) : 1'b0;
      stall_cnt_d = stall_evt ? sat_inc(stall_cnt_q) : stall_cnt_q;
      flush_cnt_d = flush_evt ? sat_inc(flush_cnt_q) : flush_cnt_q;
   end

   // State registers; reset drops any held response immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_held_q    <= 1'b0;
         d_held_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         i_held_q    <= i_held_d;
         d_held_q    <= d_held_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic,
// all compared against a rule-level reference model.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_load_regfile, ex_dcache_read;
   logic       mem_load_regfile, mem_dcache_read, mem_dcache_write, wb_load_regfile;
   logic       icache_read, icache_resp, dcache_resp, br_taken;
   control_t   ctrl;
   logic       pc_load, ibuf_load, ibuf_sel, icache_mask, dbuf_load, dbuf_sel, dcache_mask;
   logic [31:0] stall_count, flush_count;

   int n_asserts = 0;
   int n_fail    = 0;

   // reference model state
   bit     m_ih, m_dh;
   longint m_stall, m_flush;
   bit     e_fr, e_hz;

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_load_regfile(ex_load_regfile), .ex_dcache_read(ex_dcache_read),
      .mem_rd(mem_rd), .mem_load_regfile(mem_load_regfile),
      .mem_dcache_read(mem_dcache_read), .mem_dcache_write(mem_dcache_write),
      .wb_rd(wb_rd), .wb_load_regfile(wb_load_regfile),
      .icache_read(icache_read), .icache_resp(icache_resp), .dcache_resp(dcache_resp),
      .br_taken(br_taken), .ctrl(ctrl), .pc_load(pc_load),
      .ibuf_load(ibuf_load), .ibuf_sel(ibuf_sel), .icache_mask(icache_mask),
      .dbuf_load(dbuf_load), .dbuf_sel(dbuf_sel), .dcache_mask(dcache_mask),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_load_regfile = 0; ex_dcache_read = 0;
      mem_rd = 0; mem_load_regfile = 0; mem_dcache_read = 0; mem_dcache_write = 0;
      wb_rd = 0; wb_load_regfile = 0;
      icache_read = 0; icache_resp = 0; dcache_resp = 0; br_taken = 0;
   endtask

   // Newest writer of src wins; x0 never forwards.
   function automatic logic [1:0] m_fwd(input logic [4:0] src);
      if (src == 5'd0) return 2'd0;
      if (mem_load_regfile && mem_rd == src) return 2'd1;
      if (wb_load_regfile && wb_rd == src) return 2'd2;
      return 2'd0;
   endfunction

   task automatic check_all(input string tag);
      bit iw, dw;
      logic [3:0] eld, erst;
      logic epc;
      iw   = icache_read && !m_ih && !icache_resp;
      dw   = (mem_dcache_read || mem_dcache_write) && !m_dh && !dcache_resp;
      e_fr = iw || dw;
      e_hz = ex_dcache_read && ex_load_regfile && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (e_fr) begin
         eld = 4'b0000; erst = 4'b0000; epc = 1'b0;
      end else if (br_taken) begin
         eld = 4'b1111; erst = 4'b1100; epc = 1'b1;
      end else if (e_hz) begin
         eld = 4'b0111; erst = 4'b0100; epc = 1'b0;
      end else begin
         eld = 4'b1111; erst = 4'b0000; epc = 1'b1;
      end
      chk({tag, ".loads"}, 32'({ctrl.pipe_load_ifid, ctrl.pipe_load_idex,
                                 ctrl.pipe_load_exmem, ctrl.pipe_load_memwb}), 32'(eld));
      chk({tag, ".rsts"}, 32'({ctrl.pipe_rst_ifid, ctrl.pipe_rst_idex,
                                ctrl.pipe_rst_exmem, ctrl.pipe_rst_memwb}), 32'(erst));
      chk({tag, ".pc_load"}, 32'(pc_load), 32'(epc));
      chk({tag, ".rs1sel"}, 32'(ctrl.rs1mux_sel), 32'(m_fwd(ex_rs1)));
      chk({tag, ".rs2sel"}, 32'(ctrl.rs2mux_sel), 32'(m_fwd(ex_rs2)));
      chk({tag, ".ibuf_load"}, 32'(ibuf_load), 32'(icache_resp && e_fr));
      chk({tag, ".dbuf_load"}, 32'(dbuf_load), 32'(dcache_resp && e_fr));
      chk({tag, ".ibuf_sel"}, 32'(ibuf_sel), 32'(m_ih));
      chk({tag, ".icache_mask"}, 32'(icache_mask), 32'(m_ih));
      chk({tag, ".dbuf_sel"}, 32'(dbuf_sel), 32'(m_dh));
      chk({tag, ".dcache_mask"}, 32'(dcache_mask), 32'(m_dh));
      chk({tag, ".stall_count"}, stall_count, 32'(m_stall));
      chk({tag, ".flush_count"}, flush_count, 32'(m_flush));
   endtask

   task automatic model_update();
      if (e_fr) begin
         if (icache_resp) m_ih = 1;
         if (dcache_resp) m_dh = 1;
      end else begin
         m_ih = 0;
         m_dh = 0;
      end
      if (e_fr || (e_hz && !br_taken))
         m_stall = (m_stall >= 64'hFFFF_FFFF) ? m_stall : m_stall + 1;
      if (br_taken && !e_fr)
         m_flush = (m_flush >= 64'hFFFF_FFFF) ? m_flush : m_flush + 1;
   endtask

   task automatic settle(input string tag);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic advance();
      model_update();
      @(posedge clk);
      #1;
   endtask

   // Assert reset, check it acts at once, release just after a clock edge.
   task automatic apply_reset(input string tag);
      rst = 1'b1;
      m_ih = 0; m_dh = 0; m_stall = 0; m_flush = 0;
      #1;
      chk({tag, ".stall_count"}, stall_count, 32'd0);
      chk({tag, ".flush_count"}, flush_count, 32'd0);
      chk({tag, ".ibuf_sel"}, 32'(ibuf_sel), 32'd0);
      chk({tag, ".icache_mask"}, 32'(icache_mask), 32'd0);
      chk({tag, ".dbuf_sel"}, 32'(dbuf_sel), 32'd0);
      chk({tag, ".dcache_mask"}, 32'(dcache_mask), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      #1;
      apply_reset("reset");

      // idle after reset
      settle("idle");
      chk("idle.loads_const", 32'({ctrl.pipe_load_ifid, ctrl.pipe_load_idex,
                                  ctrl.pipe_load_exmem, ctrl.pipe_load_memwb}), 32'hF);
      chk("idle.pc_const", 32'(pc_load), 32'd1);
      chk("idle.sels_const", 32'({ctrl.rs1mux_sel, ctrl.rs2mux_sel}), 32'd0);
      advance();

      // load-use: lw x5 in EX, add x?,x5 in ID
      ex_dcache_read = 1; ex_load_regfile = 1; ex_rd = 5;
      id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 1;
      settle("lu");
      chk("lu.load_ifid", 32'(ctrl.pipe_load_ifid), 32'd0);
      chk("lu.pc_load", 32'(pc_load), 32'd0);
      chk("lu.rst_idex", 32'(ctrl.pipe_rst_idex), 32'd1);
      advance();
      // bubble in EX, load in MEM with an immediate data response
      clear_inputs();
      mem_rd = 5; mem_load_regfile = 1; mem_dcache_read = 1; dcache_resp = 1;
      id_rs1 = 5; id_uses_rs1 = 1;
      settle("lu_bubble");
      chk("lu_bubble.pc_load", 32'(pc_load), 32'd1);
      advance();
      // dependent add now in EX, load in WB
      clear_inputs();
      ex_rs1 = 5; wb_rd = 5; wb_load_regfile = 1;
      settle("lu_fwd");
      chk("lu_fwd.rs1sel", 32'(ctrl.rs1mux_sel), 32'd2);
      chk("lu_fwd.stall_count", stall_count, 32'd1);
      advance();

      // forwarding priority
      clear_inputs();
      mem_rd = 3; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 3; mem_load_regfile = 1; wb_load_regfile = 1;
      settle("fwd_prio");
      chk("fwd_prio.rs1sel", 32'(ctrl.rs1mux_sel), 32'd1);
      chk("fwd_prio.rs2sel", 32'(ctrl.rs2mux_sel), 32'd1);
      advance();
      mem_load_regfile = 0;
      settle("fwd_wb");
      chk("fwd_wb.rs2sel", 32'(ctrl.rs2mux_sel), 32'd2);
      advance();
      mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0; mem_load_regfile = 1;
      settle("fwd_x0");
      chk("fwd_x0.rs1sel", 32'(ctrl.rs1mux_sel), 32'd0);
      advance();

      // redirect together with load-use
      clear_inputs();
      ex_dcache_read = 1; ex_load_regfile = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
      br_taken = 1;
      settle("br_lu");
      chk("br_lu.rsts", 32'({ctrl.pipe_rst_ifid, ctrl.pipe_rst_idex,
                             ctrl.pipe_rst_exmem, ctrl.pipe_rst_memwb}), 32'b1100);
      chk("br_lu.pc_load", 32'(pc_load), 32'd1);
      advance();
      clear_inputs();
      settle("br_next");
      chk("br_next.flush_count", flush_count, 32'd1);
      advance();

      // dcache miss with fetch response held meanwhile
      apply_reset("pre_miss");
      for (int c = 0; c <= 8; c++) begin
         clear_inputs();
         icache_read     = 1;
         mem_dcache_read = (c <= 7);
         icache_resp     = (c == 3);
         dcache_resp     = (c == 7);
         settle($sformatf("miss.c%0d", c));
         if (c == 3) chk("miss.ibuf_load", 32'(ibuf_load), 32'd1);
         if (c >= 4 && c <= 7) chk("miss.icache_mask", 32'(icache_mask), 32'd1);
         if (c == 7) begin
            chk("miss.c7_loads", 32'({ctrl.pipe_load_ifid, ctrl.pipe_load_idex,
                                      ctrl.pipe_load_exmem, ctrl.pipe_load_memwb}), 32'hF);
            chk("miss.c7_ibuf_sel", 32'(ibuf_sel), 32'd1);
         end
         if (c == 8) begin
            chk("miss.c8_ibuf_sel", 32'(ibuf_sel), 32'd0);
            chk("miss.c8_stall_count", stall_count, 32'd7);
         end
         advance();
      end

      // both responses in the same cycle
      clear_inputs();
      icache_read = 1; mem_dcache_write = 1; icache_resp = 1; dcache_resp = 1;
      settle("both");
      chk("both.ibuf_load", 32'(ibuf_load), 32'd0);
      chk("both.dbuf_load", 32'(dbuf_load), 32'd0);
      chk("both.pc_load", 32'(pc_load), 32'd1);
      advance();
      clear_inputs();
      settle("both_next");
      advance();

      // reset while a fetch response is held
      icache_read = 1; mem_dcache_read = 1; icache_resp = 1;
      settle("hold_a");
      advance();
      icache_resp = 0;
      settle("hold_b");
      chk("hold_b.ibuf_sel", 32'(ibuf_sel), 32'd1);
      advance();
      apply_reset("mid_hold");
      clear_inputs();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         id_rs1           = 5'($urandom_range(0, 3));
         id_rs2           = 5'($urandom_range(0, 3));
         id_uses_rs1      = 1'($urandom_range(0, 1));
         id_uses_rs2      = 1'($urandom_range(0, 1));
         ex_rs1           = 5'($urandom_range(0, 3));
         ex_rs2           = 5'($urandom_range(0, 3));
         ex_rd            = 5'($urandom_range(0, 3));
         ex_load_regfile  = 1'($urandom_range(0, 1));
         ex_dcache_read   = 1'($urandom_range(0, 1));
         mem_rd           = 5'($urandom_range(0, 3));
         mem_load_regfile = 1'($urandom_range(0, 1));
         mem_dcache_read  = ($urandom_range(0, 3) == 0);
         mem_dcache_write = ($urandom_range(0, 5) == 0);
         wb_rd            = 5'($urandom_range(0, 3));
         wb_load_regfile  = 1'($urandom_range(0, 1));
         icache_read      = 1'($urandom_range(0, 1));
         icache_resp      = !m_ih && ($urandom_range(0, 2) == 0);
         dcache_resp      = !m_dh && ($urandom_range(0, 2) == 0);
         br_taken         = ($urandom_range(0, 5) == 0);
         settle($sformatf("rand%0d", n));
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
